// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI slave bank of NOF_DATA_WORDS 8-bit registers, command byte {R/nW, addr}, all pins oversampled in clk_i.
// Optional macro SPI_REG_BANK_WR_STROBE_EN adds wr_strobe_o / wr_addr_o write notification ports.
module spi_reg_bank #(
  parameter int         NOF_DATA_WORDS   = 4,
  parameter int         NOF_ADDRESS_BITS = 2,
  parameter int         SPI_MODE         = 0,
  parameter logic [7:0] RESET_VALUE      = 8'h00
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          miso_i,
  input  logic                          scl_i,
  input  logic                          cs_i,
  output logic                          mosi_o,
  output logic                          busy_o,
  output logic [NOF_DATA_WORDS*8-1:0]   data_o
`ifdef SPI_REG_BANK_WR_STROBE_EN
  ,
  output logic                          wr_strobe_o,
  output logic [NOF_ADDRESS_BITS-1:0]   wr_addr_o
`endif
);
  localparam int NA   = NOF_ADDRESS_BITS;
  localparam bit CPOL = SPI_MODE >= 2;
  localparam bit CPHA = (SPI_MODE % 2) == 1;
  typedef enum logic [1:0] {IDLE, CMD, WDATA, RDATA} state_e;
  state_e          state_q, state_d;
  logic [2:0]      scl_q;
  logic [1:0]      cs_q, miso_q;
  logic            armed_q, done_q, mosi_q;
  logic [2:0]      cnt_q;
  logic [7:0]      rx_q, tx_q;
  logic [NA-1:0]   addr_q, addr_d, nxt_addr;
  logic [7:0]      regs_q [2**NA];
  logic            active, smp, shf, cmd_done, dat_done, we, ld;
  logic [7:0]      ld_byte;
  function automatic logic in_rng(input logic [NA-1:0] a);
    return int'(a) < NOF_DATA_WORDS;
  endfunction
  assign active = state_q != IDLE;
  assign smp    = active & (CPOL == CPHA ? (scl_q[1] & ~scl_q[2]) : (~scl_q[1] & scl_q[2]));
  assign shf    = active & (CPOL == CPHA ? (~scl_q[1] & scl_q[2]) : (scl_q[1] & ~scl_q[2]));
  // Two-flop synchronisers; scl_q[2] is the previous synced SCL for edge detection.
  // armed_q blocks a frame already in progress when reset was released.
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      scl_q   <= {3{CPOL}};
      cs_q    <= '0;
      miso_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      scl_q   <= {scl_q[1:0], scl_i};
      cs_q    <= {cs_q[0], cs_i};
      miso_q  <= {miso_q[0], miso_i};
      armed_q <= armed_q | cs_q[1];
    end
  // FSM state register.
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) state_q <= IDLE;
    else state_q <= state_d;
  // FSM next state: CS high always returns to IDLE; the command byte picks read or write.
  always_comb begin
    state_d = state_q;
    if (cs_q[1]) state_d = IDLE;
    else if (state_q == IDLE && armed_q) state_d = CMD;
    else if (state_q == CMD && done_q) state_d = rx_q[7] ? RDATA : WDATA;
  end
  // FSM outputs: address sequencing, register write enable and tx reload.
  always_comb begin
    cmd_done = done_q & (state_q == CMD);
    dat_done = done_q & (state_q == WDATA || state_q == RDATA);
    nxt_addr = addr_q == NA'(NOF_DATA_WORDS - 1) ? '0 : addr_q + 1'b1;
    addr_d   = cmd_done ? rx_q[NA-1:0] : dat_done ? nxt_addr : addr_q;
    we       = done_q & (state_q == WDATA) & in_rng(addr_q);
    ld       = (cmd_done & rx_q[7]) | (done_q & (state_q == RDATA));
    ld_byte  = in_rng(addr_d) ? regs_q[addr_d] : 8'h00;
    busy_o   = armed_q & ~cs_q[1];
    mosi_o   = mosi_q & (state_q == RDATA);
  end
  // Datapath: bit counter, rx/tx shifters and register array.
  // With CPHA=0 the shift edge right after a byte boundary is skipped: the reload already put the MSB out.
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
      rx_q   <= '0;
      tx_q   <= '0;
      mosi_q <= 1'b0;
      addr_q <= '0;
      for (int k = 0; k < 2**NA; k++) regs_q[k] <= RESET_VALUE;
    end else begin
      cnt_q  <= active ? cnt_q + {2'b00, smp} : 3'd0;
      done_q <= smp & (cnt_q == 3'd7);
      if (smp) rx_q <= {rx_q[6:0], miso_q[1]};
      addr_q <= addr_d;
      if (we) regs_q[addr_q] <= rx_q;
      if (ld) begin
        tx_q <= CPHA ? ld_byte : {ld_byte[6:0], 1'b0};
        if (!CPHA) mosi_q <= ld_byte[7];
      end else if (shf && state_q == RDATA && (CPHA || cnt_q != 3'd0)) begin
        mosi_q <= tx_q[7];
        tx_q   <= {tx_q[6:0], 1'b0};
      end
    end
  // Flatten the register array onto data_o.
  always_comb
    for (int k = 0; k < NOF_DATA_WORDS; k++) data_o[8*k +: 8] = regs_q[k];
`ifdef SPI_REG_BANK_WR_STROBE_EN
  logic          wr_strobe_q;
  logic [NA-1:0] wr_addr_q;
  // Pulse in the cycle the written value appears on data_o; dropped writes never reach here.
  always_ff @(posedge clk_i or negedge reset_n_i)
    if (!reset_n_i) begin
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
    end else begin
      wr_strobe_q <= we;
      if (we) wr_addr_q <= addr_q;
    end
  assign wr_strobe_o = wr_strobe_q;
  assign wr_addr_o   = wr_addr_q;
`endif
endmodule

// File: tb/tb_spi_reg_bank.sv
// tb_spi_reg_bank: drives SPI modes 0..3 (4 words) plus a 3-word mode-0 bank from one master, table-driven checks.
module tb_spi_reg_bank;
  logic clk = 0, rst_n = 0, cs = 1, phase = 0, miso0 = 0, miso1 = 0;
  logic mo[5], bsy[5];
  logic [31:0] dat[4];
  logic [23:0] dat3;
  logic [7:0] got[5][3];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
`ifdef SPI_REG_BANK_WR_STROBE_EN
  logic stb[5];
  logic [1:0] wa[5];
  int scnt[5], s0[5];
  always @(posedge clk)
    for (int m = 0; m < 5; m++) if (stb[m]) scnt[m] <= scnt[m] + 1;
`endif
  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_reg_bank #(.SPI_MODE(g)) u_dut (
      .clk_i(clk), .reset_n_i(rst_n), .miso_i(g % 2 ? miso1 : miso0), .scl_i(phase ^ (g >= 2)), .cs_i(cs),
      .mosi_o(mo[g]), .busy_o(bsy[g]), .data_o(dat[g])
`ifdef SPI_REG_BANK_WR_STROBE_EN
      , .wr_strobe_o(stb[g]), .wr_addr_o(wa[g])
`endif
    );
  end
  spi_reg_bank #(.NOF_DATA_WORDS(3), .SPI_MODE(0)) u_dut3 (
    .clk_i(clk), .reset_n_i(rst_n), .miso_i(miso0), .scl_i(phase), .cs_i(cs),
    .mosi_o(mo[4]), .busy_o(bsy[4]), .data_o(dat3)
`ifdef SPI_REG_BANK_WR_STROBE_EN
    , .wr_strobe_o(stb[4]), .wr_addr_o(wa[4])
`endif
  );
  typedef struct {
    logic [7:0] cmd, d0, d1;
    int nb;
    logic [31:0] e4;
    logic [23:0] e3;
    logic [7:0] r4a, r4b, r3a, r3b;
    int s3;
    logic [1:0] wa;
  } vec_t;
  vec_t vt[7];
  vec_t v;
  function automatic bit cp(input int m);
    return m == 1 || m == 3;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", n, a, e);
    end
  endtask
  task automatic half();
    repeat (8) @(negedge clk);
  endtask
  task automatic sbyte(input logic [7:0] b, input int nbits, input int slot);
    for (int i = 7; i > 7 - nbits; i--) begin
      miso0 = b[i];
      half();
      for (int m = 0; m < 5; m++) if (!cp(m)) got[m][slot] = {got[m][slot][6:0], mo[m]};
      phase = 1;
      miso1 = b[i];
      half();
      for (int m = 0; m < 5; m++) if (cp(m)) got[m][slot] = {got[m][slot][6:0], mo[m]};
      phase = 0;
    end
  endtask
  task automatic frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int nb);
    cs = 0;
    half();
    sbyte(b0, 8, 0);
    sbyte(b1, 8, 1);
    if (nb > 1) sbyte(b2, 8, 2);
    half();
    cs = 1;
    repeat (6) @(negedge clk);
  endtask
  task automatic chk_all(input string n, input logic [31:0] e4, input logic [23:0] e3);
    for (int m = 0; m < 4; m++) chk($sformatf("%s m%0d data", n, m), dat[m], e4);
    chk({n, " n3 data"}, {8'h00, dat3}, {8'h00, e3});
  endtask
  initial begin
    vt[0] = '{8'h01, 8'hA5, 8'h3C, 2, 32'h003CA500, 24'h3CA500, 8'h00, 8'h00, 8'h00, 8'h00, 2, 2'd2};
    vt[1] = '{8'h81, 8'h00, 8'h00, 2, 32'h003CA500, 24'h3CA500, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 0, 2'd0};
    vt[2] = '{8'h03, 8'h11, 8'h22, 2, 32'h113CA522, 24'h3CA522, 8'h00, 8'h00, 8'h00, 8'h00, 1, 2'd0};
    vt[3] = '{8'h83, 8'h00, 8'h00, 2, 32'h113CA522, 24'h3CA522, 8'h11, 8'h22, 8'h00, 8'h22, 0, 2'd0};
    vt[4] = '{8'h82, 8'h00, 8'h00, 2, 32'h113CA522, 24'h3CA522, 8'h3C, 8'h11, 8'h3C, 8'h22, 0, 2'd0};
    vt[5] = '{8'h7E, 8'h5A, 8'h00, 1, 32'h115AA522, 24'h5AA522, 8'h00, 8'h00, 8'h00, 8'h00, 1, 2'd2};
    vt[6] = '{8'h03, 8'h99, 8'h00, 1, 32'h995AA522, 24'h5AA522, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'd3};
    repeat (4) @(negedge clk);
    chk_all("reset", 32'h0, 24'h0);
    for (int m = 0; m < 5; m++) begin
      chk($sformatf("reset m%0d busy", m), {31'd0, bsy[m]}, 32'd0);
      chk($sformatf("reset m%0d mosi", m), {31'd0, mo[m]}, 32'd0);
`ifdef SPI_REG_BANK_WR_STROBE_EN
      chk($sformatf("reset m%0d wr_addr", m), {30'd0, wa[m]}, 32'd0);
`endif
    end
    rst_n = 1;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 7; i++) begin
      v = vt[i];
`ifdef SPI_REG_BANK_WR_STROBE_EN
      for (int m = 0; m < 5; m++) s0[m] = scnt[m];
`endif
      frame(v.cmd, v.d0, v.d1, v.nb);
      chk_all($sformatf("v%0d", i), v.e4, v.e3);
      for (int m = 0; m < 5; m++) begin
        chk($sformatf("v%0d m%0d cmd_mosi", i, m), {24'd0, got[m][0]}, 32'd0);
        if (v.cmd[7]) begin
          chk($sformatf("v%0d m%0d rd0", i, m), {24'd0, got[m][1]}, {24'd0, m == 4 ? v.r3a : v.r4a});
          if (v.nb > 1) chk($sformatf("v%0d m%0d rd1", i, m), {24'd0, got[m][2]}, {24'd0, m == 4 ? v.r3b : v.r4b});
        end
      end
`ifdef SPI_REG_BANK_WR_STROBE_EN
      for (int m = 0; m < 4; m++) begin
        chk($sformatf("v%0d m%0d strobes", i, m), scnt[m] - s0[m], v.cmd[7] ? 0 : v.nb);
        if (!v.cmd[7]) chk($sformatf("v%0d m%0d wr_addr", i, m), {30'd0, wa[m]}, {30'd0, v.wa});
      end
      chk($sformatf("v%0d n3 strobes", i), scnt[4] - s0[4], v.s3);
`endif
    end
    cs = 0;
    half();
    sbyte(8'h00, 8, 0);
    sbyte(8'h77, 8, 1);
    for (int m = 0; m < 5; m++) chk($sformatf("abort m%0d busy_mid", m), {31'd0, bsy[m]}, 32'd1);
    sbyte(8'hFF, 4, 2);
    half();
    cs = 1;
    repeat (6) @(negedge clk);
    chk_all("abort", 32'h995AA577, 24'h5AA577);
    for (int m = 0; m < 5; m++) chk($sformatf("abort m%0d busy_end", m), {31'd0, bsy[m]}, 32'd0);
    frame(8'h81, 8'h00, 8'h00, 1);
    for (int m = 0; m < 5; m++) chk($sformatf("post_abort m%0d rd0", m), {24'd0, got[m][1]}, 32'h000000A5);
`ifdef SPI_REG_BANK_WR_STROBE_EN
    for (int m = 0; m < 5; m++) s0[m] = scnt[m];
`endif
    cs = 0;
    half();
    sbyte(8'h00, 8, 0);
    sbyte(8'hAA, 4, 1);
    rst_n = 0;
    #1;
    chk_all("rst_mid", 32'h0, 24'h0);
    for (int m = 0; m < 5; m++) chk($sformatf("rst_mid m%0d busy", m), {31'd0, bsy[m]}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    sbyte(8'h55, 8, 1);
    sbyte(8'h66, 8, 2);
    for (int m = 0; m < 5; m++) chk($sformatf("rst_tail m%0d busy", m), {31'd0, bsy[m]}, 32'd0);
    half();
    cs = 1;
    repeat (6) @(negedge clk);
    chk_all("rst_tail", 32'h0, 24'h0);
`ifdef SPI_REG_BANK_WR_STROBE_EN
    for (int m = 0; m < 5; m++) chk($sformatf("rst_tail m%0d strobes", m), scnt[m] - s0[m], 0);
`endif
    frame(8'h00, 8'h55, 8'h00, 1);
    chk_all("rst_new", 32'h00000055, 24'h000055);
    frame(8'h80, 8'h00, 8'h00, 1);
    for (int m = 0; m < 5; m++) chk($sformatf("rst_new m%0d rd0", m), {24'd0, got[m][1]}, 32'h00000055);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
